// File: rtl/rx_serial_pkg.sv
// Shared definitions for the 7E1 serial receiver: state codes, frame width
// and the default bit period (50 MHz / 115200 baud).
package rx_serial_pkg;

    localparam int DATA_BITS            = 7;
    localparam int CLKS_PER_BIT_DEFAULT = 434;

    // Codes are exported raw on db_estado, so the values are fixed.
    typedef enum logic [3:0] {
        ESPERA     = 4'd0,
        VALIDA     = 4'd1,
        DADOS      = 4'd2,
        PARIDADE   = 4'd3,
        STOP       = 4'd4,
        FINAL      = 4'd5,
        ERRO_LINHA = 4'd6
    } estado_t;

endpackage

// File: rtl/rx_serial_uc.sv
// Control FSM of the 7E1 receiver. Walks start validation, seven data bits,
// parity and stop, and emits the datapath strobes:
//   zera     - clear baud counter and bit index, latch the parity select
//   conta    - advance the baud counter
//   desloca  - shift the mid-bit sample into the data register
//   amostra  - capture the parity bit
//   registra - load the output registers with the finished frame
module rx_serial_uc
    import rx_serial_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_s,
    input  logic       fim_meio,
    input  logic       fim_bit,
    input  logic       ultimo,
    input  logic       stop_erro,
    output logic       zera,
    output logic       conta,
    output logic       amostra,
    output logic       desloca,
    output logic       registra,
    output logic [3:0] db_estado
);

    estado_t estado_q;

    // State register and transition rules.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= ESPERA;
        end else begin
            case (estado_q)
                ESPERA:     if (!rx_s) estado_q <= VALIDA;
                VALIDA:     if (fim_meio) estado_q <= rx_s ? ESPERA : DADOS;
                DADOS:      if (fim_bit && ultimo) estado_q <= PARIDADE;
                PARIDADE:   if (fim_bit) estado_q <= STOP;
                STOP:       if (fim_bit) estado_q <= FINAL;
                // A zero stop bit means the line may be stuck low or in a
                // break; wait for it to rise before looking for a new start.
                FINAL:      estado_q <= stop_erro ? ERRO_LINHA : ESPERA;
                ERRO_LINHA: if (rx_s) estado_q <= ESPERA;
                default:    estado_q <= ESPERA;
            endcase
        end
    end

    // Decode the datapath strobes from the current state.
    always_comb begin
        zera     = 1'b0;
        conta    = 1'b0;
        amostra  = 1'b0;
        desloca  = 1'b0;
        registra = 1'b0;
        case (estado_q)
            ESPERA, FINAL, ERRO_LINHA: zera = 1'b1;
            VALIDA: begin
                // Restart the counter at mid-start so the following samples
                // land in the middle of each bit.
                zera  = fim_meio;
                conta = !fim_meio;
            end
            DADOS: begin
                conta   = 1'b1;
                desloca = fim_bit;
            end
            PARIDADE: begin
                conta   = 1'b1;
                amostra = fim_bit;
            end
            STOP: begin
                conta    = 1'b1;
                registra = fim_bit;
            end
            default: zera = 1'b1;
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: rtl/rx_serial_7e1.sv
// 7E1 asynchronous serial receiver: 7 data bits LSB first, one parity bit
// (even/odd selectable), one stop bit. Holds the datapath (synchronizer,
// mod-CLKS_PER_BIT baud counter, bit index, shift register, output
// registers) around the rx_serial_uc control FSM.
// Optional feature macro: RX_BUFFER_FLAG_EN adds consome / tem_dado /
// erro_overrun for a one-character receive buffer flag.
module rx_serial_7e1
    import rx_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int CNT_W        = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dados_serial,
    input  logic       paridade,
`ifdef RX_BUFFER_FLAG_EN
    input  logic       consome,
    output logic       tem_dado,
    output logic       erro_overrun,
`endif
    output logic [6:0] dados_ascii,
    output logic       pronto,
    output logic       erro_paridade,
    output logic       erro_stop,
    output logic [3:0] db_estado
);

    localparam logic [CNT_W-1:0] CNT_MEIO = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FIM  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_ULT  = 3'(DATA_BITS - 1);

    logic sync1_q, sync2_q, rx_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [6:0] sr_q, sr_d;
    logic pbit_q, pbit_d;
    logic par_sel_q, par_sel_d;
    logic [6:0] dados_ascii_q, dados_ascii_d;
    logic pronto_q, pronto_d;
    logic erro_paridade_q, erro_paridade_d;
    logic erro_stop_q, erro_stop_d;
`ifdef RX_BUFFER_FLAG_EN
    logic tem_dado_q, tem_dado_d;
    logic erro_overrun_q, erro_overrun_d;
`endif

    logic zera, conta, amostra, desloca, registra;
    logic fim_meio, fim_bit, ultimo;

    // Two-flop synchronizer for the asynchronous RX pin; idles high.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= dados_serial;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s     = sync2_q;
    assign fim_meio = (cnt_q == CNT_MEIO);
    assign fim_bit  = (cnt_q == CNT_FIM);
    assign ultimo   = (idx_q == IDX_ULT);

    rx_serial_uc u_uc (
        .clock     (clock),
        .reset     (reset),
        .rx_s      (rx_s),
        .fim_meio  (fim_meio),
        .fim_bit   (fim_bit),
        .ultimo    (ultimo),
        .stop_erro (erro_stop_q),
        .zera      (zera),
        .conta     (conta),
        .amostra   (amostra),
        .desloca   (desloca),
        .registra  (registra),
        .db_estado (db_estado)
    );

    // Next-state values for the counter, shift path and output registers.
    always_comb begin
        cnt_d           = cnt_q;
        idx_d           = idx_q;
        par_sel_d       = par_sel_q;
        sr_d            = sr_q;
        pbit_d          = pbit_q;
        dados_ascii_d   = dados_ascii_q;
        erro_paridade_d = erro_paridade_q;
        erro_stop_d     = erro_stop_q;
        pronto_d        = registra;

        // Baud counter wraps every bit period so samples stay mid-bit.
        if (zera) begin
            cnt_d = '0;
        end else if (conta) begin
            cnt_d = fim_bit ? '0 : cnt_q + 1'b1;
        end

        // The last zera before DADOS is the start validation, so the parity
        // select seen there is the one used for the whole frame.
        if (zera) begin
            idx_d     = '0;
            par_sel_d = paridade;
        end else if (desloca) begin
            idx_d = idx_q + 3'd1;
        end

        if (desloca) sr_d = {rx_s, sr_q[6:1]};
        if (amostra) pbit_d = rx_s;

        // The stop bit is taken straight from rx_s at its mid-bit sample.
        if (registra) begin
            dados_ascii_d   = sr_q;
            erro_paridade_d = (^sr_q) ^ pbit_q ^ par_sel_q;
            erro_stop_d     = ~rx_s;
        end
    end

`ifdef RX_BUFFER_FLAG_EN
    // Buffer flag: a new frame wins over a simultaneous consume.
    always_comb begin
        tem_dado_d     = tem_dado_q;
        erro_overrun_d = erro_overrun_q | (registra & tem_dado_q);
        if (registra) begin
            tem_dado_d = 1'b1;
        end else if (consome) begin
            tem_dado_d = 1'b0;
        end
    end

    // Buffer flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            tem_dado_q     <= 1'b0;
            erro_overrun_q <= 1'b0;
        end else begin
            tem_dado_q     <= tem_dado_d;
            erro_overrun_q <= erro_overrun_d;
        end
    end

    assign tem_dado     = tem_dado_q;
    assign erro_overrun = erro_overrun_q;
`endif

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q           <= '0;
            idx_q           <= '0;
            par_sel_q       <= 1'b0;
            sr_q            <= '0;
            pbit_q          <= 1'b0;
            dados_ascii_q   <= '0;
            pronto_q        <= 1'b0;
            erro_paridade_q <= 1'b0;
            erro_stop_q     <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            par_sel_q       <= par_sel_d;
            sr_q            <= sr_d;
            pbit_q          <= pbit_d;
            dados_ascii_q   <= dados_ascii_d;
            pronto_q        <= pronto_d;
            erro_paridade_q <= erro_paridade_d;
            erro_stop_q     <= erro_stop_d;
        end
    end

    assign dados_ascii   = dados_ascii_q;
    assign pronto        = pronto_q;
    assign erro_paridade = erro_paridade_q;
    assign erro_stop     = erro_stop_q;

endmodule

// File: tb/tb_rx_serial_7e1.sv
// Bench for rx_serial_7e1: drives whole 7E1 frames on dados_serial and
// compares each pronto capture against a frame-level reference model.
module tb_rx_serial_7e1;

    localparam int CLKS = 434;

    logic       clock = 1'b0;
    logic       reset;
    logic       dados_serial;
    logic       paridade;
    logic [6:0] dados_ascii;
    logic       pronto;
    logic       erro_paridade;
    logic       erro_stop;
    logic [3:0] db_estado;
`ifdef RX_BUFFER_FLAG_EN
    logic       consome;
    logic       tem_dado;
    logic       erro_overrun;
`endif

    rx_serial_7e1 #(.CLKS_PER_BIT(CLKS), .CNT_W(9)) dut (
        .clock         (clock),
        .reset         (reset),
        .dados_serial  (dados_serial),
        .paridade      (paridade),
`ifdef RX_BUFFER_FLAG_EN
        .consome       (consome),
        .tem_dado      (tem_dado),
        .erro_overrun  (erro_overrun),
`endif
        .dados_ascii   (dados_ascii),
        .pronto        (pronto),
        .erro_paridade (erro_paridade),
        .erro_stop     (erro_stop),
        .db_estado     (db_estado)
    );

    // Clock and cycle counter.
    always #10 clock = ~clock;
    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard entries are {char, parity error, stop error}.
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic [8:0] last_exp = '0;
    int pronto_cnt = 0;
    int pronto_hi  = 0;
    int unsigned last_pronto_cyc = 0;
    int unsigned start_cyc = 0;
    logic prev_pronto = 1'b0;

    // Monitor: captures outputs on every rising pronto.
    always @(negedge clock) begin
        if (pronto === 1'b1) begin
            pronto_hi++;
            if (!prev_pronto) begin
                pronto_cnt++;
                got_q.push_back({dados_ascii, erro_paridade, erro_stop});
                last_pronto_cyc = cyc;
            end
        end
        prev_pronto = (pronto === 1'b1);
    end

    // Reference model: parity error when the count of ones in data+pbit
    // does not match the selected parity (0 = even, 1 = odd).
    function automatic logic [8:0] model(input logic [6:0] ch, input logic pbit,
                                         input logic stop_bit, input logic sel);
        int ones;
        ones = $countones(ch) + int'(pbit);
        return {ch, ((ones % 2) != int'(sel)), ~stop_bit};
    endfunction

    task automatic expect_frame(input logic [6:0] ch, input logic pbit,
                                input logic stop_bit, input logic sel);
        last_exp = model(ch, pbit, stop_bit, sel);
        exp_q.push_back(last_exp);
    endtask

    // Drives one frame; called at a negedge, returns at a negedge with the
    // line left at the stop-bit level. Optionally flips paridade mid-frame.
    task automatic send_frame(input logic [6:0] ch, input logic pbit,
                              input logic stop_bit, input logic sel, input logic flip);
        paridade     = sel;
        dados_serial = 1'b0;
        start_cyc    = cyc;
        repeat (CLKS) @(negedge clock);
        if (flip) paridade = ~sel;
        for (int i = 0; i < 7; i++) begin
            dados_serial = ch[i];
            repeat (CLKS) @(negedge clock);
        end
        dados_serial = pbit;
        repeat (CLKS) @(negedge clock);
        dados_serial = stop_bit;
        repeat (CLKS) @(negedge clock);
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        dados_serial = 1'b1;
        paridade     = 1'b0;
`ifdef RX_BUFFER_FLAG_EN
        consome      = 1'b0;
`endif
        repeat (5) @(negedge clock);
        n_checks++;
        if ({dados_ascii, pronto, erro_paridade, erro_stop, db_estado} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ascii=%h pronto=%b ep=%b es=%b est=%0d, want all 0",
                     dados_ascii, pronto, erro_paridade, erro_stop, db_estado);
        end
        reset = 1'b0;
        repeat (10) @(negedge clock);
    endtask

    task automatic test_even_a();
        logic [8:0] g, e;
        expect_frame(7'h41, 1'b0, 1'b1, 1'b0);
        send_frame(7'h41, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (50) @(negedge clock);
        n_checks++;
        if (pronto_cnt !== 1) begin
            n_fail++;
            $display("FAIL even_a_count: got %0d pronto pulses, want 1", pronto_cnt);
        end
        n_checks++;
        if ((last_pronto_cyc - start_cyc) < 4125 || (last_pronto_cyc - start_cyc) > 4127) begin
            n_fail++;
            $display("FAIL even_a_latency: got %0d clocks, want 4126",
                     last_pronto_cyc - start_cyc);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL even_a_frame: got %h/%b/%b want %h/%b/%b",
                         g[8:2], g[1], g[0], e[8:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_parity();
        logic [8:0] g, e;
        int base;
        base = pronto_cnt;
        expect_frame(7'h41, 1'b0, 1'b1, 1'b1);
        send_frame(7'h41, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (30) @(negedge clock);
        expect_frame(7'h43, 1'b1, 1'b1, 1'b0);
        send_frame(7'h43, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (50) @(negedge clock);
        n_checks++;
        if (pronto_cnt - base !== 2) begin
            n_fail++;
            $display("FAIL parity_count: got %0d pronto pulses, want 2", pronto_cnt - base);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL parity_frame: got %h/%b/%b want %h/%b/%b",
                         g[8:2], g[1], g[0], e[8:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_glitch();
        int base;
        base = pronto_cnt;
        dados_serial = 1'b0;
        repeat (50) @(negedge clock);
        n_checks++;
        if (db_estado !== 4'd1) begin
            n_fail++;
            $display("FAIL glitch_valida: got state %0d, want 1", db_estado);
        end
        repeat (50) @(negedge clock);
        dados_serial = 1'b1;
        repeat (600) @(negedge clock);
        n_checks++;
        if (pronto_cnt !== base || db_estado !== 4'd0) begin
            n_fail++;
            $display("FAIL glitch_ignored: got %0d pulses state %0d, want 0 pulses state 0",
                     pronto_cnt - base, db_estado);
        end
        n_checks++;
        if ({dados_ascii, erro_paridade, erro_stop} !== last_exp) begin
            n_fail++;
            $display("FAIL glitch_hold: got %h/%b/%b want %h/%b/%b", dados_ascii,
                     erro_paridade, erro_stop, last_exp[8:2], last_exp[1], last_exp[0]);
        end
    endtask

    task automatic test_stop_error();
        logic [8:0] g, e;
        int base;
        base = pronto_cnt;
        expect_frame(7'h41, 1'b0, 1'b0, 1'b0);
        send_frame(7'h41, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2000) @(negedge clock);
        n_checks++;
        if (db_estado !== 4'd6) begin
            n_fail++;
            $display("FAIL stop_err_state: got state %0d, want 6", db_estado);
        end
        dados_serial = 1'b1;
        repeat (600) @(negedge clock);
        n_checks++;
        if (pronto_cnt - base !== 1 || db_estado !== 4'd0) begin
            n_fail++;
            $display("FAIL stop_err_recover: got %0d pulses state %0d, want 1 pulse state 0",
                     pronto_cnt - base, db_estado);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL stop_err_frame: got %h/%b/%b want %h/%b/%b",
                         g[8:2], g[1], g[0], e[8:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [8:0] g, e;
        logic [6:0] ch;
        int base;
        ch = 7'h5A;
        base = pronto_cnt;
        paridade = 1'b0;
        dados_serial = 1'b0;
        repeat (CLKS) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            dados_serial = ch[i];
            repeat (CLKS) @(negedge clock);
        end
        dados_serial = ch[3];
        repeat (CLKS / 2) @(negedge clock);
        reset = 1'b1;
        dados_serial = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({dados_ascii, pronto, erro_paridade, erro_stop, db_estado} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got ascii=%h pronto=%b ep=%b es=%b est=%0d, want all 0",
                     dados_ascii, pronto, erro_paridade, erro_stop, db_estado);
        end
        reset = 1'b0;
        repeat (20) @(negedge clock);
        expect_frame(ch, ^ch, 1'b1, 1'b0);
        send_frame(ch, ^ch, 1'b1, 1'b0, 1'b0);
        repeat (50) @(negedge clock);
        n_checks++;
        if (pronto_cnt - base !== 1) begin
            n_fail++;
            $display("FAIL reset_mid_count: got %0d pronto pulses, want 1", pronto_cnt - base);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL reset_mid_frame: got %h/%b/%b want %h/%b/%b",
                         g[8:2], g[1], g[0], e[8:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] g, e;
        int unsigned t1;
        int base, base_hi;
        base = pronto_cnt;
        base_hi = pronto_hi;
`ifdef RX_BUFFER_FLAG_EN
        consome = 1'b1;
        @(negedge clock);
        consome = 1'b0;
        @(negedge clock);
        n_checks++;
        if (tem_dado !== 1'b0 || erro_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_flags_before: got tem_dado=%b overrun=%b, want 0 0",
                     tem_dado, erro_overrun);
        end
`endif
        expect_frame(7'h61, 1'b1, 1'b1, 1'b0);
        expect_frame(7'h62, 1'b1, 1'b1, 1'b0);
        send_frame(7'h61, 1'b1, 1'b1, 1'b0, 1'b0);
        t1 = last_pronto_cyc;
        send_frame(7'h62, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (50) @(negedge clock);
        n_checks++;
        if (pronto_cnt - base !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d pronto pulses, want 2", pronto_cnt - base);
        end
        n_checks++;
        if (last_pronto_cyc - t1 !== 10 * CLKS) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d clocks, want %0d", last_pronto_cyc - t1, 10 * CLKS);
        end
        n_checks++;
        if (pronto_hi - base_hi !== pronto_cnt - base) begin
            n_fail++;
            $display("FAIL b2b_pulse_width: got %0d high cycles for %0d pulses, want equal",
                     pronto_hi - base_hi, pronto_cnt - base);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL b2b_frame: got %h/%b/%b want %h/%b/%b",
                         g[8:2], g[1], g[0], e[8:2], e[1], e[0]);
            end
        end
`ifdef RX_BUFFER_FLAG_EN
        n_checks++;
        if (tem_dado !== 1'b1 || erro_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_overrun: got tem_dado=%b overrun=%b, want 1 1",
                     tem_dado, erro_overrun);
        end
`endif
    endtask

    task automatic test_random();
        logic [8:0] g, e;
        logic [6:0] ch;
        logic pbit, stop_bit, sel;
        int base;
        base = pronto_cnt;
        for (int n = 0; n < 6; n++) begin
            ch       = 7'($urandom_range(0, 127));
            pbit     = 1'($urandom_range(0, 1));
            sel      = 1'($urandom_range(0, 1));
            stop_bit = ($urandom_range(0, 3) != 0);
            expect_frame(ch, pbit, stop_bit, sel);
            send_frame(ch, pbit, stop_bit, sel, 1'b1);
            dados_serial = 1'b1;
            repeat ($urandom_range(5, 300)) @(negedge clock);
        end
        repeat (50) @(negedge clock);
        n_checks++;
        if (pronto_cnt - base !== 6 || got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL random_count: got %0d pulses (%0d captured, %0d expected), want 6",
                     pronto_cnt - base, got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL random_frame: got %h/%b/%b want %h/%b/%b",
                         g[8:2], g[1], g[0], e[8:2], e[1], e[0]);
            end
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_even_a();
        test_parity();
        test_glitch();
        test_stop_error();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
